mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 55 +++++
 rtl/mem_port_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters (CPU, UART/IO), the shared
// single-port synchronous RAM and the memory port arbiter.
//   cpu_* / io_* : request, write flag, address, write data in;
//                  grant, one-cycle done pulse, read data out
//   mem_*        : shared RAM port (address, write data, write enable out;
//                  read data in, valid one cycle after the address)
//   busy         : arbiter is in the middle of an access
// Modports: slave = arbiter side, master = requester/RAM side.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_done;
    logic [DATA_W-1:0] cpu_rdata;

    logic              io_req;
    logic              io_we;
    logic [ADDR_W-1:0] io_addr;
    logic [DATA_W-1:0] io_wdata;
    logic              io_gnt;
    logic              io_done;
    logic [DATA_W-1:0] io_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_done, cpu_rdata,
        input  io_req, io_we, io_addr, io_wdata,
        output io_gnt, io_done, io_rdata,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata,
        output busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_done, cpu_rdata,
        output io_req, io_we, io_addr, io_wdata,
        input  io_gnt, io_done, io_rdata,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a shared single-port synchronous RAM.
// Each access takes IDLE -> ACCESS (grant + RAM cycle) -> RESP (done pulse,
// read data) -> IDLE, so one requester can be served every third cycle.
//
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : mem_port_arbiter_if.slave (CPU and IO request/response sets,
//           shared RAM port, busy flag)
//
// Build option:
//   MEM_ARB_ROUND_ROBIN_EN defined   -> simultaneous requests alternate,
//                                       the requester not served last wins.
//   MEM_ARB_ROUND_ROBIN_EN undefined -> fixed priority, CPU over IO.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_ACCESS = 2'b01;
    localparam logic [1:0] ST_RESP   = 2'b10;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_IO  = 1'b1;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              owner;
    logic              owner_nxt;
    logic              hold_we;
    logic              hold_we_nxt;
    logic [ADDR_W-1:0] hold_addr;
    logic [ADDR_W-1:0] hold_addr_nxt;
    logic [DATA_W-1:0] hold_wdata;
    logic [DATA_W-1:0] hold_wdata_nxt;

    logic              cpu_gnt_q;
    logic              cpu_gnt_nxt;
    logic              io_gnt_q;
    logic              io_gnt_nxt;
    logic              cpu_done_q;
    logic              cpu_done_nxt;
    logic              io_done_q;
    logic              io_done_nxt;
    logic              mem_we_q;
    logic              mem_we_nxt;
    logic              busy_q;
    logic              busy_nxt;

    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] io_rdata_q;
    logic              rd_resp_cpu;
    logic              rd_resp_io;

    logic              any_req;
    logic              winner;

    assign any_req = bus.cpu_req | bus.io_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Last-served pointer; resets to IO so the CPU wins the first tie.
    logic last_served;

    always_comb begin
        winner = OWN_IO;
        if (bus.cpu_req && bus.io_req) begin
            winner = (last_served == OWN_IO) ? OWN_CPU : OWN_IO;
        end else if (bus.cpu_req) begin
            winner = OWN_CPU;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_served <= OWN_IO;
        end else if ((state == ST_IDLE) && any_req) begin
            last_served <= winner;
        end
    end
`else
    // Fixed priority: the CPU always wins a tie.
    assign winner = bus.cpu_req ? OWN_CPU : OWN_IO;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, latched request, and next values of the registered outputs
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        hold_we_nxt    = hold_we;
        hold_addr_nxt  = hold_addr;
        hold_wdata_nxt = hold_wdata;

        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_nxt      = ST_ACCESS;
                    owner_nxt      = winner;
                    hold_we_nxt    = (winner == OWN_CPU) ? bus.cpu_we    : bus.io_we;
                    hold_addr_nxt  = (winner == OWN_CPU) ? bus.cpu_addr  : bus.io_addr;
                    hold_wdata_nxt = (winner == OWN_CPU) ? bus.cpu_wdata : bus.io_wdata;
                end
            end
            ST_ACCESS: state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase

        // Outputs are decoded from the state being entered so they line up
        // with that state once registered.
        cpu_gnt_nxt  = (state_nxt == ST_ACCESS) && (owner_nxt == OWN_CPU);
        io_gnt_nxt   = (state_nxt == ST_ACCESS) && (owner_nxt == OWN_IO);
        cpu_done_nxt = (state_nxt == ST_RESP) && (owner_nxt == OWN_CPU);
        io_done_nxt  = (state_nxt == ST_RESP) && (owner_nxt == OWN_IO);
        mem_we_nxt   = (state_nxt == ST_ACCESS) && hold_we_nxt;
        busy_nxt     = (state_nxt != ST_IDLE);
    end

    // Owner, holding registers and registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            owner      <= OWN_CPU;
            hold_we    <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
            cpu_gnt_q  <= 1'b0;
            io_gnt_q   <= 1'b0;
            cpu_done_q <= 1'b0;
            io_done_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            owner      <= owner_nxt;
            hold_we    <= hold_we_nxt;
            hold_addr  <= hold_addr_nxt;
            hold_wdata <= hold_wdata_nxt;
            cpu_gnt_q  <= cpu_gnt_nxt;
            io_gnt_q   <= io_gnt_nxt;
            cpu_done_q <= cpu_done_nxt;
            io_done_q  <= io_done_nxt;
            mem_we_q   <= mem_we_nxt;
            busy_q     <= busy_nxt;
        end
    end

    // Read completions: RAM data arrives during RESP
    assign rd_resp_cpu = (state == ST_RESP) && (owner == OWN_CPU) && !hold_we;
    assign rd_resp_io  = (state == ST_RESP) && (owner == OWN_IO)  && !hold_we;

    // Per-requester read data, held until that requester's next read
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rdata_q <= '0;
            io_rdata_q  <= '0;
        end else begin
            if (rd_resp_cpu) begin
                cpu_rdata_q <= bus.mem_rdata;
            end
            if (rd_resp_io) begin
                io_rdata_q <= bus.mem_rdata;
            end
        end
    end

    // RAM data is forwarded during RESP so rdata is valid with done.
    assign bus.cpu_rdata = rd_resp_cpu ? bus.mem_rdata : cpu_rdata_q;
    assign bus.io_rdata  = rd_resp_io  ? bus.mem_rdata : io_rdata_q;

    // Handshakes and busy are masked while reset is held; mem_we is not,
    // so a write already on the RAM port in the reset cycle still lands.
    assign bus.cpu_gnt  = cpu_gnt_q  & ~reset;
    assign bus.io_gnt   = io_gnt_q   & ~reset;
    assign bus.cpu_done = cpu_done_q & ~reset;
    assign bus.io_done  = io_done_q  & ~reset;
    assign bus.busy     = busy_q     & ~reset;
    assign bus.mem_we   = mem_we_q;

    // RAM address/data always come from the holding registers.
    assign bus.mem_addr  = hold_addr;
    assign bus.mem_wdata = hold_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed transactions against a RAM model,
// a transaction-level reference model compared every cycle, and literal
// checks of latency, data and arbitration order.
module tb_mem_port_arbiter;

    logic clk;
    logic reset;

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_tests;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared RAM: synchronous write and registered read
    logic [15:0] ram [0:65535];
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A transaction is accepted when a request is seen while no transaction
    // is in flight; its grant/RAM cycle is the next cycle and its done/read
    // data the one after. age = cycles since acceptance (0 = nothing in flight).
    int          age;
    logic        t_own;     // 0 = CPU, 1 = IO
    logic        t_we;
    logic [15:0] t_addr;
    logic [15:0] t_wdata;
    logic [15:0] e_rdata [2];
    logic [15:0] mram [logic [15:0]];
    bit          model_live;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic        last_io;
`endif

    function automatic logic [15:0] mread(input logic [15:0] a);
        return mram.exists(a) ? mram[a] : 16'h0000;
    endfunction

    always @(posedge clk) begin
        if (age == 1 && t_we) mram[t_addr] = t_wdata;
        if (reset) begin
            age = 0; t_own = 1'b0; t_we = 1'b0; t_addr = 16'h0; t_wdata = 16'h0;
            e_rdata[0] = 16'h0; e_rdata[1] = 16'h0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_io = 1'b1;
`endif
        end else if (age == 1) begin
            age = 2;
        end else if (age == 2) begin
            age = 0;
        end else if (bus.cpu_req || bus.io_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (bus.cpu_req && bus.io_req) t_own = !last_io;
            else                           t_own = bus.io_req;
            last_io = t_own;
`else
            t_own = !bus.cpu_req;
`endif
            t_we    = t_own ? bus.io_we    : bus.cpu_we;
            t_addr  = t_own ? bus.io_addr  : bus.cpu_addr;
            t_wdata = t_own ? bus.io_wdata : bus.cpu_wdata;
            age = 1;
        end
        if (age == 2 && !t_we) e_rdata[t_own] = mread(t_addr);
        model_live = 1'b1;
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (model_live) begin
            check("cpu_gnt",   32'(bus.cpu_gnt),   32'(age == 1 && t_own == 1'b0 && !reset));
            check("io_gnt",    32'(bus.io_gnt),    32'(age == 1 && t_own == 1'b1 && !reset));
            check("cpu_done",  32'(bus.cpu_done),  32'(age == 2 && t_own == 1'b0 && !reset));
            check("io_done",   32'(bus.io_done),   32'(age == 2 && t_own == 1'b1 && !reset));
            check("busy",      32'(bus.busy),      32'(age != 0 && !reset));
            check("mem_we",    32'(bus.mem_we),    32'(age == 1 && t_we));
            check("mem_addr",  32'(bus.mem_addr),  32'(t_addr));
            check("mem_wdata", 32'(bus.mem_wdata), 32'(t_wdata));
            check("cpu_rdata", 32'(bus.cpu_rdata), 32'(e_rdata[0]));
            check("io_rdata",  32'(bus.io_rdata),  32'(e_rdata[1]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit who, input bit req, input bit we,
                           input logic [15:0] a, input logic [15:0] d);
        if (who) begin
            bus.io_req = req; bus.io_we = we; bus.io_addr = a; bus.io_wdata = d;
        end else begin
            bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
        end
    endtask

    function automatic logic gnt_of(input bit who);
        return who ? bus.io_gnt : bus.cpu_gnt;
    endfunction

    function automatic logic done_of(input bit who);
        return who ? bus.io_done : bus.cpu_done;
    endfunction

    // One complete request: raise, wait (bounded) for done, drop for a cycle.
    // Cycle 0 is the cycle the request is first visible.
    task automatic run_txn(input bit who, input bit we, input logic [15:0] a, input logic [15:0] d,
                           output int g_at, output int d_at, output int busy_n,
                           output int we_n, output logic [15:0] we_addr);
        g_at = -1; d_at = -1; busy_n = 0; we_n = 0; we_addr = 16'h0;
        set_req(who, 1'b1, we, a, d);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (gnt_of(who) && g_at < 0) g_at = k;
            if (bus.busy) busy_n++;
            if (bus.mem_we) begin
                we_n++;
                we_addr = bus.mem_addr;
            end
            if (done_of(who)) begin
                d_at = k;
                break;
            end
        end
        tick();
        set_req(who, 1'b0, we, a, d);
        tick();
    endtask

    int          g_at, d_at, busy_n, we_n, nd;
    logic [15:0] we_addr;
    int          gcyc [4];
    logic        gwho [4];
    int          ng, io_seen;
    logic        exp_who;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0; n_fail = 0; age = 0; model_live = 1'b0;
        for (int i = 0; i < 65536; i++) ram[i] = 16'h0000;
        ram[16'h0010] = 16'hBEEF;
        mram[16'h0010] = 16'hBEEF;
        reset = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        set_req(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (3) tick();
        @(negedge clk);
        check("rst_busy",      32'(bus.busy),      32'h0);
        check("rst_mem_we",    32'(bus.mem_we),    32'h0);
        check("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'h0);
        check("rst_io_rdata",  32'(bus.io_rdata),  32'h0);
        tick();
        reset = 1'b0;
        tick();

        // CPU read of preloaded word
        run_txn(1'b0, 1'b0, 16'h0010, 16'h0, g_at, d_at, busy_n, we_n, we_addr);
        check("rd_gnt_cycle",  32'(g_at), 32'd1);
        check("rd_done_cycle", 32'(d_at), 32'd2);
        check("rd_busy_cnt",   32'(busy_n), 32'd2);
        check("rd_cpu_rdata",  32'(bus.cpu_rdata), 32'hBEEF);

        // IO write
        run_txn(1'b1, 1'b1, 16'h3FFF, 16'h00A5, g_at, d_at, busy_n, we_n, we_addr);
        check("wr_we_cnt",     32'(we_n), 32'd1);
        check("wr_we_addr",    32'(we_addr), 32'h3FFF);
        check("wr_done_cycle", 32'(d_at), 32'd2);
        check("wr_io_rdata",   32'(bus.io_rdata), 32'h0);

        // Write-then-read pairs, including top of the address range
        run_txn(1'b0, 1'b1, 16'h0020, 16'h1234, g_at, d_at, busy_n, we_n, we_addr);
        run_txn(1'b0, 1'b0, 16'h0020, 16'h0,    g_at, d_at, busy_n, we_n, we_addr);
        check("wr_rd_0020", 32'(bus.cpu_rdata), 32'h1234);
        run_txn(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, g_at, d_at, busy_n, we_n, we_addr);
        run_txn(1'b1, 1'b0, 16'hFFFF, 16'h0,    g_at, d_at, busy_n, we_n, we_addr);
        check("wr_rd_ffff", 32'(bus.io_rdata), 32'hFFFF);
        check("cpu_rdata_kept", 32'(bus.cpu_rdata), 32'h1234);
        run_txn(1'b0, 1'b1, 16'h0030, 16'h5555, g_at, d_at, busy_n, we_n, we_addr);
        check("write_keeps_rdata", 32'(bus.cpu_rdata), 32'h1234);

        // Simultaneous held requests, first tie after reset
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin gcyc[i] = -1; gwho[i] = 1'b0; end
        ng = 0; io_seen = 0;
        set_req(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
        set_req(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0);
        for (int k = 0; k < 30 && ng < 4; k++) begin
            @(negedge clk);
            if (bus.io_gnt) io_seen++;
            if (bus.cpu_gnt || bus.io_gnt) begin
                gcyc[ng] = k;
                gwho[ng] = bus.io_gnt;
                ng++;
            end
        end
        check("tie_grant_cnt", 32'(ng), 32'd4);
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_who = (i % 2 == 1);
`else
            exp_who = 1'b0;
`endif
            check("tie_grant_who",   32'(gwho[i]), 32'(exp_who));
            check("tie_grant_cycle", 32'(gcyc[i]), 32'(1 + 3 * i));
        end
`ifndef MEM_ARB_ROUND_ROBIN_EN
        check("tie_io_starved", 32'(io_seen), 32'd0);
`endif
        tick();
        set_req(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0);
        set_req(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0);
        repeat (3) tick();

        // Reset during the ACCESS cycle of a CPU write
        set_req(1'b0, 1'b1, 1'b1, 16'h0040, 16'h7777);
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("rst_acc_we_issued", 32'(bus.mem_we),  32'h1);
        check("rst_acc_gnt_mask",  32'(bus.cpu_gnt), 32'h0);
        tick();
        reset = 1'b0;
        set_req(1'b0, 1'b0, 1'b1, 16'h0040, 16'h7777);
        nd = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check("rst_acc_busy",      32'(bus.busy),      32'h0);
                check("rst_acc_cpu_rdata", 32'(bus.cpu_rdata), 32'h0);
                check("rst_acc_io_rdata",  32'(bus.io_rdata),  32'h0);
            end
            if (bus.cpu_done) nd++;
        end
        check("rst_acc_no_done", 32'(nd), 32'd0);
        tick();
        run_txn(1'b0, 1'b0, 16'h0040, 16'h0, g_at, d_at, busy_n, we_n, we_addr);
        check("post_rst_gnt_cycle",  32'(g_at), 32'd1);
        check("post_rst_done_cycle", 32'(d_at), 32'd2);
        check("post_rst_rdata",      32'(bus.cpu_rdata), 32'h7777);

        // IO request dropped during ACCESS still completes
        set_req(1'b1, 1'b1, 1'b0, 16'h3FFF, 16'h0);
        tick();
        set_req(1'b1, 1'b0, 1'b0, 16'h3FFF, 16'h0);
        @(negedge clk);
        check("drop_io_gnt", 32'(bus.io_gnt), 32'h1);
        @(negedge clk);
        check("drop_io_done",  32'(bus.io_done),  32'h1);
        check("drop_io_rdata", 32'(bus.io_rdata), 32'h00A5);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
